// File: rtl/filter_pkg.sv
// Shared definitions for the filter controller: default frame geometry,
// field widths and offsets of the filter word, and the controller state type.
package filter_pkg;

  localparam int unsigned IMG_W_DEF     = 1280;
  localparam int unsigned IMG_H_DEF     = 960;
  localparam int unsigned FLUSH_CYC_DEF = IMG_W_DEF + 2;
  localparam int          COEF_DEF      = 2;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned PIX_W   = 12;
  localparam int unsigned CONST_W = 3;

  // fdata = {valid[34], y[33:23], x[22:12], pix[11:0]}
  localparam int unsigned FD_PIX_LSB   = 0;
  localparam int unsigned FD_X_LSB     = 12;
  localparam int unsigned FD_Y_LSB     = 23;
  localparam int unsigned FD_VALID_BIT = 34;
  localparam int unsigned FD_W         = 35;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] y;
    logic [CNT_W-1:0] x;
    logic [PIX_W-1:0] pix;
  } fdata_t;

endpackage

// File: rtl/filter_coord_cnt.sv
// Raster coordinate counter: x advances per inc, wraps at IMG_W-1 and bumps y.
// Holds at the final pixel of the frame so it never runs past the last coordinate.
// Ports: clk, rst_n, clr (synchronous clear), inc (advance one pixel),
//        x / y (current coordinate), last_c (current coordinate is the final pixel).
module filter_coord_cnt
  import filter_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             last_c
);

  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(IMG_H - 1);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;

  assign last_c = (x_q == X_MAX) && (y_q == Y_MAX);
  assign x      = x_q;
  assign y      = y_q;

  // Next coordinate; clear has priority over advance.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (inc && !last_c) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/filter_ctrl.sv
// Frame controller feeding the filter grid: accepts a raster of pixels, tags each
// with its (x, y) coordinate, drains the pipeline with flush words, then pulses
// frame_done. Also drives the static filter configuration (weights, boundaries).
// Ports: clk, rst_n; start/mode/abort control; pix_valid/pix_data/pix_ready
//        upstream stream; fdata filter word; vertical, v_constant, h_constant,
//        x_dc, y_dc filter configuration; busy, frame_done status.
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int unsigned IMG_W     = IMG_W_DEF,
  parameter int unsigned IMG_H     = IMG_H_DEF,
  parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int          COEF      = COEF_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic               abort,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  output logic               pix_ready,
  output logic [FD_W-1:0]    fdata,
  output logic               vertical,
  output logic [CONST_W-1:0] v_constant,
  output logic [CONST_W-1:0] h_constant,
  output logic [CNT_W-1:0]   x_dc,
  output logic [CNT_W-1:0]   y_dc,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned     FL_W   = $clog2(FLUSH_CYC + 1);
  localparam logic [FL_W-1:0] FL_MAX = FL_W'(FLUSH_CYC - 1);

  state_e            state_q, state_d;
  fdata_t            fdata_q, fdata_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic              vertical_q, vertical_d;
  logic              pix_ready_q, pix_ready_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [CONST_W-1:0] v_const_q, h_const_q;
  logic [CNT_W-1:0]  x_dc_q, y_dc_q;

  logic              cnt_clr, cnt_inc, last_c;
  logic [CNT_W-1:0]  x_c, y_c;

  filter_coord_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_coord (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .x      (x_c),
    .y      (y_c),
    .last_c (last_c)
  );

  // Next state, datapath word and status. fdata carries one cycle of latency,
  // so frame_done lands on the cycle after DONE, where abort can still veto it.
  always_comb begin
    state_d      = state_q;
    fdata_d      = '0;
    flush_d      = flush_q;
    vertical_d   = vertical_q;
    frame_done_d = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_RUN;
          vertical_d = mode;
          cnt_clr    = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (pix_valid) begin
          fdata_d.valid = 1'b1;
          fdata_d.y     = y_c;
          fdata_d.x     = x_c;
          fdata_d.pix   = pix_data;
          cnt_inc       = 1'b1;
          if (last_c) begin
            state_d = ST_FLUSH;
            flush_d = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          fdata_d.valid = 1'b1;
          fdata_d.y     = CNT_W'(IMG_H - 1);
          fdata_d.x     = CNT_W'(IMG_W - 1);
          if (flush_q == FL_MAX) begin
            state_d = ST_DONE;
          end else begin
            flush_d = flush_q + FL_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) begin
          cnt_clr = 1'b1;
        end else begin
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pix_ready_d = (state_d == ST_RUN);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fdata_q      <= '0;
      flush_q      <= '0;
      vertical_q   <= 1'b0;
      pix_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      v_const_q    <= '0;
      h_const_q    <= '0;
      x_dc_q       <= '0;
      y_dc_q       <= '0;
    end else begin
      state_q      <= state_d;
      fdata_q      <= fdata_d;
      flush_q      <= flush_d;
      vertical_q   <= vertical_d;
      pix_ready_q  <= pix_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      // Static filter configuration, reloaded every cycle after reset.
      v_const_q    <= CONST_W'(COEF);
      h_const_q    <= CONST_W'(-COEF);
      x_dc_q       <= '0;
      y_dc_q       <= CNT_W'(IMG_H - 1);
    end
  end

  assign fdata      = fdata_q;
  assign vertical   = vertical_q;
  assign pix_ready  = pix_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign v_constant = v_const_q;
  assign h_constant = h_const_q;
  assign x_dc       = x_dc_q;
  assign y_dc       = y_dc_q;

endmodule
